// File: rtl/aes_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// aes_pkg: shared AES datapath widths and SubBytes FSM state encoding
// Rev 1.0
// ------------------------------------------------------------------
package aes_pkg;

  localparam int AES_STATE_W   = 128;
  localparam int AES_BYTE_W    = 8;
  localparam int AES_NB        = 4;
  localparam int AES_NUM_BYTES = AES_NB * 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_e;

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ------------------------------------------------------------------
// aes_sbox: combinational FIPS-197 forward S-box lookup
// Rev 1.0
// ------------------------------------------------------------------
module aes_sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] iByte,
  output logic [AES_BYTE_W-1:0] oByte
);

  localparam logic [7:0] C_SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign oByte = C_SBOX[iByte];

endmodule : aes_sbox
`default_nettype wire

// File: rtl/sub_bytes_serial.sv
`default_nettype none
// ------------------------------------------------------------------
// sub_bytes_serial: iterative AES SubBytes, LANES bytes per RUN cycle
// Rev 1.0
// ------------------------------------------------------------------
module sub_bytes_serial
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   iClk,
  input  logic                   iRst_n,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic [AES_STATE_W-1:0] iData,
  output logic                   oValid,
  input  logic                   iReady,
  output logic [AES_STATE_W-1:0] oData
);

  localparam int STEPS = AES_NUM_BYTES / LANES;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
    $error("sub_bytes_serial: LANES must be 1, 2, 4, 8 or 16");
  end

  aes_state_e             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [AES_STATE_W-1:0] r_work;
  logic [AES_STATE_W-1:0] r_data;

  logic [4:0]             w_base;
  logic [AES_BYTE_W-1:0]  w_sin [LANES];
  logic [AES_BYTE_W-1:0]  w_sub [LANES];
  logic [AES_STATE_W-1:0] w_next;

  // First byte index of the group substituted this cycle
  assign w_base = 5'(int'(r_cnt) * LANES);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_sin[g] = r_work[{w_base + 5'(g), 3'b000} +: AES_BYTE_W];

    aes_sbox u_sbox (
      .iByte (w_sin[g]),
      .oByte (w_sub[g])
    );
  end

  always_comb begin
    w_next = r_work;
    for (int l = 0; l < LANES; l++) begin
      w_next[{w_base + 5'(l), 3'b000} +: AES_BYTE_W] = w_sub[l];
    end
  end

  // r_data is only loaded on the final RUN cycle so partial results never leak out
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (iValid) begin
            r_work  <= iData;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_work <= w_next;
          if (r_cnt == CNT_W'(STEPS - 1)) begin
            r_cnt   <= '0;
            r_data  <= w_next;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (iReady) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign oReady = (r_state == IDLE);
  assign oValid = (r_state == DONE);
  assign oData  = r_data;

endmodule : sub_bytes_serial
`default_nettype wire

// File: tb/tb_sub_bytes_serial.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_sub_bytes_serial: directed-vector bench for sub_bytes_serial
// Rev 1.0
// ------------------------------------------------------------------
module tb_sub_bytes_serial;

  localparam logic [127:0] C_VEC_A = 128'h08_48_f8_e9_2a_8d_c6_9a_2b_e2_f4_a0_be_e3_3d_19;
  localparam logic [127:0] C_EXP_A = 128'h30_52_41_1e_e5_5d_b4_b8_f1_98_bf_e0_ae_11_27_d4;
  localparam logic [127:0] C_VEC_Z = 128'h0;
  localparam logic [127:0] C_EXP_Z = {16{8'h63}};
  localparam logic [127:0] C_VEC_B = 128'h53;
  localparam logic [127:0] C_EXP_B = {{15{8'h63}}, 8'hed};

  logic         clk;
  logic         rst_n;
  logic         valid_in;
  logic         ready_out;
  logic [127:0] data_in;
  logic         valid_out;
  logic         ready_in;
  logic [127:0] data_out;

  logic [3:0]   sw_valid_in;
  logic [3:0]   sw_ready_in;
  logic [3:0]   sw_ready_out;
  logic [3:0]   sw_valid_out;
  logic [127:0] sw_data_in;
  logic [127:0] sw_data_out [4];

  int total;
  int bad;

  sub_bytes_serial #(.LANES(4)) u_dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .iValid (valid_in),
    .oReady (ready_out),
    .iData  (data_in),
    .oValid (valid_out),
    .iReady (ready_in),
    .oData  (data_out)
  );

  // Sweep instances with LANES = 1, 2, 8, 16
  for (genvar i = 0; i < 4; i++) begin : g_sweep
    localparam int E = (i < 2) ? i : i + 1;
    sub_bytes_serial #(.LANES(1 << E)) u_sw (
      .iClk   (clk),
      .iRst_n (rst_n),
      .iValid (sw_valid_in[i]),
      .oReady (sw_ready_out[i]),
      .iData  (sw_data_in),
      .oValid (sw_valid_out[i]),
      .iReady (sw_ready_in[i]),
      .oData  (sw_data_out[i])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!valid_out && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready_out); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_out); end
    total++; if (data_out !== 128'h0) begin bad++; $display("FAIL reset_data got=%h want=0", data_out); end
    rst_n = 1'b1;
    tick();
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", ready_out); end
  endtask

  task automatic test_fips();
    int cyc;
    valid_in = 1'b1;
    data_in  = C_VEC_A;
    tick();
    valid_in = 1'b0;
    data_in  = '0;
    total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL fips_busy got=%b want=0", ready_out); end
    wait_valid(cyc);
    total++; if (cyc != 4) begin bad++; $display("FAIL fips_latency got=%0d want=4", cyc); end
    total++; if (data_out !== C_EXP_A) begin bad++; $display("FAIL fips_data got=%h want=%h", data_out, C_EXP_A); end
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    total++; if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      bad++; $display("FAIL fips_release got valid=%b ready=%b want 0/1", valid_out, ready_out);
    end
  endtask

  task automatic run_one(input logic [127:0] vec, input logic [127:0] exp, input logic [127:0] prev, input string nm);
    int cyc;
    valid_in = 1'b1;
    data_in  = vec;
    tick();
    valid_in = 1'b0;
    tick();
    total++; if (data_out !== prev) begin bad++; $display("FAIL %s_no_partial got=%h want=%h", nm, data_out, prev); end
    wait_valid(cyc);
    total++; if (data_out !== exp) begin bad++; $display("FAIL %s_data got=%h want=%h", nm, data_out, exp); end
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
  endtask

  task automatic test_patterns();
    run_one(C_VEC_Z, C_EXP_Z, C_EXP_A, "zero");
    run_one(C_VEC_B, C_EXP_B, C_EXP_Z, "byte53");
  endtask

  task automatic test_backpressure();
    int cyc;
    valid_in = 1'b1;
    data_in  = C_VEC_A;
    tick();
    valid_in = 1'b0;
    wait_valid(cyc);
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (valid_out !== 1'b1 || ready_out !== 1'b0 || data_out !== C_EXP_A) begin
        bad++; $display("FAIL bp_hold_%0d got valid=%b ready=%b data=%h want 1/0/%h", k, valid_out, ready_out, data_out, C_EXP_A);
      end
    end
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    total++; if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      bad++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", valid_out, ready_out);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    valid_in = 1'b1;
    data_in  = C_VEC_Z;
    tick();
    data_in  = C_VEC_B;
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    wait_valid(cyc);
    total++; if (cyc != 3) begin bad++; $display("FAIL b2b_first_latency got=%0d want=3", cyc); end
    total++; if (data_out !== C_EXP_Z) begin bad++; $display("FAIL b2b_first_data got=%h want=%h", data_out, C_EXP_Z); end
    total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL b2b_no_capture got=%b want=0", ready_out); end
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    total++; if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
      bad++; $display("FAIL b2b_idle got ready=%b valid=%b want 1/0", ready_out, valid_out);
    end
    tick();
    valid_in = 1'b0;
    data_in  = '0;
    wait_valid(cyc);
    total++; if (cyc != 4) begin bad++; $display("FAIL b2b_second_latency got=%0d want=4", cyc); end
    total++; if (data_out !== C_EXP_B) begin bad++; $display("FAIL b2b_second_data got=%h want=%h", data_out, C_EXP_B); end
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int cyc;
    valid_in = 1'b1;
    data_in  = C_VEC_A;
    tick();
    valid_in = 1'b0;
    tick();
    rst_n = 1'b0;
    #2;
    total++; if (valid_out !== 1'b0 || data_out !== 128'h0 || ready_out !== 1'b1) begin
      bad++; $display("FAIL midrun_async got valid=%b ready=%b data=%h want 0/1/0", valid_out, ready_out, data_out);
    end
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (valid_out !== 1'b0 || data_out !== 128'h0 || ready_out !== 1'b1) begin
      bad++; $display("FAIL midrun_release got valid=%b ready=%b data=%h want 0/1/0", valid_out, ready_out, data_out);
    end
    valid_in = 1'b1;
    data_in  = C_VEC_Z;
    tick();
    valid_in = 1'b0;
    wait_valid(cyc);
    total++; if (cyc != 4 || data_out !== C_EXP_Z) begin
      bad++; $display("FAIL midrun_fresh got lat=%0d data=%h want 4/%h", cyc, data_out, C_EXP_Z);
    end
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
  endtask

  task automatic test_lanes_sweep();
    int lat [4];
    int exp_lat [4];
    logic [127:0] got [4];
    exp_lat = '{16, 8, 2, 1};
    for (int i = 0; i < 4; i++) begin
      lat[i] = -1;
      got[i] = '0;
    end
    sw_valid_in = 4'hf;
    sw_data_in  = C_VEC_A;
    tick();
    sw_valid_in = 4'h0;
    sw_data_in  = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (lat[i] < 0 && sw_valid_out[i]) begin
          lat[i] = c;
          got[i] = sw_data_out[i];
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (lat[i] != exp_lat[i]) begin bad++; $display("FAIL sweep_latency_%0d got=%0d want=%0d", i, lat[i], exp_lat[i]); end
      total++; if (got[i] !== C_EXP_A) begin bad++; $display("FAIL sweep_data_%0d got=%h want=%h", i, got[i], C_EXP_A); end
    end
    total++; if (sw_ready_out !== 4'h0) begin bad++; $display("FAIL sweep_busy got=%b want=0000", sw_ready_out); end
    sw_ready_in = 4'hf;
    tick();
    sw_ready_in = 4'h0;
    total++; if (sw_ready_out !== 4'hf || sw_valid_out !== 4'h0) begin
      bad++; $display("FAIL sweep_release got ready=%b valid=%b want 1111/0000", sw_ready_out, sw_valid_out);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    valid_in    = 1'b0;
    ready_in    = 1'b0;
    data_in     = '0;
    sw_valid_in = 4'h0;
    sw_ready_in = 4'h0;
    sw_data_in  = '0;
    test_reset();
    test_fips();
    test_patterns();
    test_backpressure();
    test_back_to_back();
    test_reset_midrun();
    test_lanes_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sub_bytes_serial
`default_nettype wire

// File: doc/sub_bytes_serial.md
Name: sub_bytes_serial

Overview:
Iterative AES SubBytes stage that sits directly upstream of the combinational ShiftRows block and feeds its iData. It accepts one 128-bit state per transaction through a valid/ready handshake. It substitutes LANES bytes per clock through shared S-box instances, then holds the result until the consumer accepts it. This trades S-box area against latency for the DE10 AES datapath.

Parameters:
LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16; other values are a compile-time error.
STEPS, 16/LANES (derived localparam, not overridable), number of RUN cycles per state.

Ports:
iClk  input  1  system clock, rising edge
iRst_n  input  1  asynchronous active-low reset
iValid  input  1  upstream presents a state on iData
oReady  output  1  block can accept a state this cycle
iData  input  128  input state; byte k = iData[8k+:8], column-major (row r, column c at k = 4c+r)
oValid  output  1  oData holds a completed SubBytes result
iReady  input  1  downstream accepts oData this cycle
oData  output  128  substituted state, same byte layout as iData

Behaviour:
- Reset (asynchronous assert, synchronous release on iClk): state=IDLE, step counter=0, work register=0, oData=0, oValid=0. oReady=1 once in IDLE.
- FSM states: IDLE, RUN, DONE. oReady = (state==IDLE). oValid = (state==DONE). Both are decoded from registered state; no combinational path from iValid/iReady to outputs.
- IDLE: on iValid&&oReady, capture iData into the work register, clear the counter, go to RUN. Otherwise stay in IDLE. iData is ignored when iValid=0.
- RUN: each cycle, byte indices [cnt*LANES, cnt*LANES+LANES-1] of the work register are replaced by their S-box images. Bytes are processed in ascending index order. cnt increments by 1. When cnt==STEPS-1, the last group is written, cnt returns to 0, and state goes to DONE.
- DONE: oData = work register, stable while oValid=1. On iReady=1, go to IDLE (one-cycle handshake). iReady=0 holds DONE indefinitely, with oData unchanged.
- Latency: input handshake at edge T, then oValid=1 after edge T+STEPS (T+4 for LANES=4, T+16 for LANES=1, T+1 for LANES=16). Throughput is one state per STEPS+2 cycles minimum (IDLE cycle, STEPS RUN cycles, DONE cycle).
- No overlap: oReady=0 in RUN and DONE. iValid asserted during these states is not captured, and upstream must hold it.
- iValid and iReady toggling in RUN has no effect.
- oData reflects the work register only in DONE. In IDLE/RUN it holds its last completed value (0 after reset) and does not expose partial results.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values and the in-flight state is discarded. After release, the block is ready in IDLE on the next cycle.
- Counter width is clog2(STEPS), minimum 1 bit. For LANES=16 the counter is unused and RUN lasts exactly 1 cycle.

Decomposition:
- Shared package aes_pkg: AES_STATE_W=128, AES_BYTE_W=8, AES_NB=4, state encoding constants (IDLE, RUN, DONE).
- Sub-module aes_sbox: 8-bit in, 8-bit out, purely combinational FIPS-197 forward S-box table. It is instantiated LANES times via generate and is reusable by key expansion.
- The FSM and counter live in sub_bytes_serial; no further hierarchy.

Test Plan:
- FIPS-197 App. B round-1 input, bytes 0..15 = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08 -> oData bytes 0..15 = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30, with oValid exactly 4 cycles after the accept edge (LANES=4).
- iData=0 -> oData bytes all 0x63. Also byte0=0x53, others 0x00 -> byte0=0xed, others 0x63.
- Backpressure: iReady=0 for 6 cycles after oValid -> oValid stays 1, oData constant, oReady stays 0. iReady=1 -> next cycle oValid=0, oReady=1.
- iValid held high with a second state while in RUN/DONE -> second state is captured only after return to IDLE, and both results are correct and in order.
- Reset pulse in 2nd RUN cycle -> oValid=0, oData=0, oReady=1 right after release. A fresh state then completes correctly.
- Parameter sweep LANES=1/2/8/16 with the App. B vector -> identical oData, latencies 16/8/2/1 cycles.
